// File: rtl/arcade_input_cond.sv
// arcade_input_cond: PS/2 key and joystick conditioning for the arcade core, with paced coin pulses.
// Build option AUTOFIRE_EN: pad bit 8 gates a square-wave autofire onto the fire outputs.
module arcade_input_cond #(
  parameter int unsigned COIN_PULSE = 120000,
  parameter int unsigned COIN_GAP   = 120000,
  parameter int unsigned AF_DIV     = 600000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        rotate,
  output logic        up1,
  output logic        down1,
  output logic        left1,
  output logic        right1,
  output logic        fire1,
  output logic        up2,
  output logic        down2,
  output logic        left2,
  output logic        right2,
  output logic        fire2,
  output logic        start1,
  output logic        start2,
  output logic        coin1,
  output logic        test
);

  localparam int unsigned MAX_CG  = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
  localparam int unsigned MAX_CNT = (AF_DIV > MAX_CG) ? AF_DIV : MAX_CG;
  localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam int unsigned K_N  = 14;
  localparam int unsigned K_UP = 0;
  localparam int unsigned K_DN = 1;
  localparam int unsigned K_LF = 2;
  localparam int unsigned K_RT = 3;
  localparam int unsigned K_FI = 4;
  localparam int unsigned K_S1 = 5;
  localparam int unsigned K_S2 = 6;
  localparam int unsigned K_CO = 7;
  localparam int unsigned K_U2 = 8;
  localparam int unsigned K_D2 = 9;
  localparam int unsigned K_L2 = 10;
  localparam int unsigned K_R2 = 11;
  localparam int unsigned K_F2 = 12;
  localparam int unsigned K_TS = 13;

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} coin_state_t;

  logic             tog_q;
  logic             key_evt;
  logic [K_N-1:0]   key_sel;
  logic [K_N-1:0]   keys;
  logic             u1_s, d1_s, l1_s, r1_s, u2_s, d2_s, l2_s, r2_s;
  logic             s1_m, s2_m;
  logic             af1, af2;
  logic             coin_src, coin_src_q, coin_req;
  coin_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pend, pend_nxt;
  logic             coin_nxt;
  logic             unused_bits;

  assign unused_bits = ^{joystick_0[15:8], joystick_1[15:8]};
  assign key_evt     = ps2_key[10] ^ tog_q;

  // Scancode to key-latch select; codes marked plain-only are rejected when extended.
  always_comb begin
    key_sel = '0;
    case (ps2_key[7:0])
      8'h75:        key_sel[K_UP] = 1'b1;
      8'h72:        key_sel[K_DN] = 1'b1;
      8'h6B:        key_sel[K_LF] = 1'b1;
      8'h74:        key_sel[K_RT] = 1'b1;
      8'h14:        key_sel[K_FI] = 1'b1;
      8'h29:        key_sel[K_FI] = ~ps2_key[8];
      8'h05, 8'h16: key_sel[K_S1] = ~ps2_key[8];
      8'h06, 8'h1E: key_sel[K_S2] = ~ps2_key[8];
      8'h2E, 8'h36: key_sel[K_CO] = ~ps2_key[8];
      8'h2D:        key_sel[K_U2] = 1'b1;
      8'h2B:        key_sel[K_D2] = 1'b1;
      8'h23:        key_sel[K_L2] = 1'b1;
      8'h34:        key_sel[K_R2] = 1'b1;
      8'h1C:        key_sel[K_F2] = 1'b1;
      8'h2C:        key_sel[K_TS] = ~ps2_key[8];
      default:      key_sel = '0;
    endcase
  end

  // Toggle copy loads the live input on reset so no event is seen on release.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tog_q      <= ps2_key[10];
      keys       <= '0;
      coin_src_q <= 1'b0;
    end else begin
      tog_q      <= ps2_key[10];
      coin_src_q <= coin_src;
      if (key_evt) keys <= (keys & ~key_sel) | (key_sel & {K_N{ps2_key[9]}});
    end
  end

  always_comb begin
    u1_s     = keys[K_UP] | joystick_0[3];
    d1_s     = keys[K_DN] | joystick_0[2];
    l1_s     = keys[K_LF] | joystick_0[1];
    r1_s     = keys[K_RT] | joystick_0[0];
    u2_s     = keys[K_U2] | joystick_1[3];
    d2_s     = keys[K_D2] | joystick_1[2];
    l2_s     = keys[K_L2] | joystick_1[1];
    r2_s     = keys[K_R2] | joystick_1[0];
    s1_m     = keys[K_S1] | joystick_0[5] | joystick_1[5];
    s2_m     = keys[K_S2] | joystick_0[6] | joystick_1[6];
    coin_src = keys[K_CO] | joystick_0[7] | joystick_1[7] | s1_m | s2_m;
    coin_req = coin_src & ~coin_src_q;
  end

`ifdef AUTOFIRE_EN
  logic [CNT_W-1:0] af_cnt;
  logic             af_ph;

  // Free-running half-period divider for the autofire square wave.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      af_cnt <= '0;
      af_ph  <= 1'b0;
    end else if (af_cnt == CNT_W'(AF_DIV - 1)) begin
      af_cnt <= '0;
      af_ph  <= ~af_ph;
    end else begin
      af_cnt <= af_cnt + CNT_W'(1);
    end
  end

  assign af1 = joystick_0[8] & af_ph;
  assign af2 = joystick_1[8] & af_ph;
`else
  assign af1 = 1'b0;
  assign af2 = 1'b0;
`endif

  // Coin FSM state register.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      pend  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pend  <= pend_nxt;
    end
  end

  // Coin FSM next state; one-deep pending request, counter reloaded on each entry.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend;
    case (state)
      S_IDLE: begin
        if (coin_req) begin
          state_nxt = S_PULSE;
          cnt_nxt   = CNT_W'(COIN_PULSE - 1);
        end
      end
      S_PULSE: begin
        if (coin_req) pend_nxt = 1'b1;
        if (cnt == '0) begin
          state_nxt = S_GAP;
          cnt_nxt   = CNT_W'(COIN_GAP - 1);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt == '0) begin
          pend_nxt = 1'b0;
          if (pend || coin_req) begin
            state_nxt = S_PULSE;
            cnt_nxt   = CNT_W'(COIN_PULSE - 1);
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          if (coin_req) pend_nxt = 1'b1;
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Coin FSM output decode, registered below with the other controls.
  always_comb begin
    coin_nxt = (state_nxt == S_PULSE);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      {up1, down1, left1, right1, fire1} <= '0;
      {up2, down2, left2, right2, fire2} <= '0;
      {start1, start2, coin1, test}      <= '0;
    end else begin
      up1    <= rotate ? l1_s : u1_s;
      down1  <= rotate ? r1_s : d1_s;
      left1  <= rotate ? d1_s : l1_s;
      right1 <= rotate ? u1_s : r1_s;
      fire1  <= keys[K_FI] | joystick_0[4] | af1;
      up2    <= rotate ? l2_s : u2_s;
      down2  <= rotate ? r2_s : d2_s;
      left2  <= rotate ? d2_s : l2_s;
      right2 <= rotate ? u2_s : r2_s;
      fire2  <= keys[K_F2] | joystick_1[4] | af2;
      start1 <= s1_m;
      start2 <= s2_m;
      coin1  <= coin_nxt;
      test   <= keys[K_TS];
    end
  end

endmodule

// File: doc/arcade_input_cond.md
Name: arcade_input_cond

Overview:
Input conditioning stage directly upstream of the arcade game core. It consumes the raw PS/2 key event word and both joystick words from hps_io and produces registered, per-player arcade control lines for the core. Coin requests are converted into fixed-length, paced coin pulses.

Parameters:
COIN_PULSE, 120000, length of the coin1 high pulse in clk_sys cycles (10 ms at 12 MHz).
COIN_GAP, 120000, minimum coin1 low time after each pulse, in cycles.
AF_DIV, 600000, autofire half-period in cycles. Used only with AUTOFIRE_EN.

Ports:
clk_sys  in  1  system clock; every register is clocked on the rising edge.
reset  in  1  synchronous, active-high reset.
ps2_key  in  11  [10] toggles once per event; [9] is 1 for pressed; [8] is the extended flag; [7:0] is the scancode.
joystick_0  in  16  player-1 pad: [0]R [1]L [2]D [3]U [4]fire [5]start1 [6]start2 [7]coin.
joystick_1  in  16  player-2 pad, same layout.
rotate  in  1  1 means horizontal orientation: directions are remapped (status[2]).
up1, down1, left1, right1, fire1  out  1 each  player-1 controls.
up2, down2, left2, right2, fire2  out  1 each  player-2 controls.
start1, start2  out  1 each  start buttons.
coin1  out  1  paced coin pulse.
test  out  1  service/test key.

Behaviour:
- Clock and reset: one clock, clk_sys. reset is synchronous and active-high.
- Reset state: all outputs 0, all key latches 0, coin FSM in IDLE, pending flag 0. The internal copy of ps2_key[10] loads the current input value, so no phantom event follows reset.
- Key event detect: an event occurs when ps2_key[10] differs from its registered copy (one cycle behind). On an event, the matching latch is set to ps2_key[9].
- Key decode table (unlisted codes are ignored):
  - Extended or plain 75 = up, 72 = down, 6B = left, 74 = right, 14 = fire.
  - Plain 29 = fire.
  - Plain 05 and 16 = start1. Plain 06 and 1E = start2.
  - Plain 2E and 36 = coin.
  - Player 2: 2D = up2, 2B = down2, 23 = left2, 34 = right2, 1C = fire2.
  - Plain 2C = test.
- Pad merge: player 1 = key latches OR joystick_0. Player 2 = player-2 key latches OR joystick_1.
- Rotation, with rotate=1:
  - up := left source, down := right source, left := down source, right := up source.
  - Applied per player after the merge.
  - fire, start and coin are never rotated.
- Latency: all outputs are registered. joystick to output is 1 cycle. ps2_key toggle to output is 2 cycles (event detect, then latch, then output register).
- Coin request: a rising edge of coin_src. coin_src = OR of the coin key latch, joystick_0[7], joystick_1[7], start1 and start2, where start1/start2 are the post-merge values. Start buttons insert a coin (free-coin convention).
- Coin FSM:
  - IDLE: on a request, go to PULSE and load the counter with COIN_PULSE-1. coin1 rises on the cycle after the request.
  - PULSE: coin1=1. Decrement each cycle. At 0, go to GAP and load COIN_GAP-1.
  - GAP: coin1=0. Decrement. At 0, go to IDLE. If pending=1, go straight to PULSE instead and clear pending.
  - A request arriving in PULSE or GAP sets pending. It is one deep: further requests while pending=1 are dropped.
  - A request in the same cycle that GAP expires is taken directly (→PULSE). pending is not set.
- Simultaneous key event and joystick change: both are applied; OR semantics.
- reset asserted mid-pulse: coin1=0 on the next cycle and pending is cleared.
- Counter width: $clog2(max(COIN_PULSE, COIN_GAP, AF_DIV)) bits, unsigned. The counter never wraps: it is reloaded on every state entry.

Optional Feature:
AUTOFIRE_EN.
- Defined:
  - Free-running AF counter with a square-wave toggle bit af_ph, period 2*AF_DIV cycles. Reset clears af_ph and the counter.
  - joystick bit [8] (either pad) held: the corresponding fireN output = af_ph, ORed with the normal fire path.
- Undefined: bit [8] is ignored, fireN is the plain merged value, and no AF counter is synthesised.

Test Plan:
1. Reset, then toggle ps2_key[10] with {pressed=1, 0x75}: up1=1 exactly 2 cycles later. A second toggle with pressed=0: up1=0 2 cycles later.
2. rotate=1, joystick_0=16'h0002 (left): up1=1, left1=0, 1 cycle later. rotate=0: left1=1, up1=0.
3. COIN_PULSE=4, COIN_GAP=3; joystick_0[7] rising at cycle t: coin1 high for cycles t+1..t+4, low for at least 3 cycles.
4. Same parameters; second request during PULSE plus a third during GAP: exactly 2 pulses, 3 low cycles between them; the third request is dropped.
5. Assert reset on the 2nd cycle of a coin pulse: coin1=0 the next cycle. No further pulse after reset is released with inputs idle.
6. With AUTOFIRE_EN and AF_DIV=5, hold joystick_1 bit [8]: fire2 toggles every 5 cycles. Without the macro, fire2 stays 0.
